// File: rtl/riscv_mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: states, ALU codes,
// datapath select values and the immediate-format decode.
package riscv_mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR1  = 4'd11,
    S_JALR2  = 4'd12,
    S_LUI    = 4'd13,
    S_TRAP   = 4'd15
  } stateT;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } aluCtrlT;

  // How the ALU decoder should interpret funct3/funct7 in the current state
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluOpT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Datapath strobes and selects produced by the sequencer each cycle
  typedef struct packed {
    logic       pcWrEn;
    logic       adrSrc;
    logic       memWrEn;
    logic       irWrEn;
    logic       regWrEn;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       instrDone;
  } ctrlT;

  function automatic logic [2:0] immSrcOf(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_fsm_if.sv
// Control/status bundle between the sequencer (master) and the shared datapath (slave).
interface riscv_mc_ctrl_fsm_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       memReady;

  logic       pcWrEn;
  logic       adrSrc;
  logic       memWrEn;
  logic       irWrEn;
  logic       regWrEn;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluCtrl;
  logic [2:0] immSrc;
  logic [3:0] state;
  logic       instrDone;
  logic       trap;

  modport master (
    input  opcode, funct3, funct7b5, zero, lt, memReady,
    output pcWrEn, adrSrc, memWrEn, irWrEn, regWrEn, resultSrc, aluSrcA, aluSrcB,
           aluCtrl, immSrc, state, instrDone, trap
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, lt, memReady,
    input  pcWrEn, adrSrc, memWrEn, irWrEn, regWrEn, resultSrc, aluSrcA, aluSrcB,
           aluCtrl, immSrc, state, instrDone, trap
  );

endinterface

// File: rtl/riscv_mc_ctrl_fsm_aludec.sv
// ALU operation decode from funct3/funct7[5]; flags the funct3 encodings this core lacks.
module riscv_mc_ctrl_fsm_aludec
  import riscv_mc_ctrl_fsm_pkg::*;
(
  input  aluOpT      aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output aluCtrlT    aluCtrl,
  output logic       illegal
);

  always_comb begin
    aluCtrl = ALU_ADD;
    illegal = 1'b0;
    case (aluOp)
      ALUOP_ADD: aluCtrl = ALU_ADD;
      ALUOP_SUB: aluCtrl = ALU_SUB;
      default: begin
        // SUB only exists in the register form; addi ignores bit 30
        case (funct3)
          3'b000:  aluCtrl = (aluOp == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  aluCtrl = ALU_AND;
          3'b110:  aluCtrl = ALU_OR;
          3'b100:  aluCtrl = ALU_XOR;
          3'b010:  aluCtrl = ALU_SLT;
          3'b001:  aluCtrl = ALU_SLL;
          3'b101:  aluCtrl = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl_fsm.sv
// Multicycle RV32I sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback, stalls on memory wait states and traps on bad encodings or timeout.
module riscv_mc_ctrl_fsm
  import riscv_mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                clk,
  input  logic                rst,
  riscv_mc_ctrl_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  ctrlT             ctrl;
  ctrlT             ctrlOut;
  aluOpT            aluOp;
  aluCtrlT          aluCtrl;
  logic             aluIllegal;
  logic             memWait;
  logic             memTimeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  assign memWait    = (state inside {S_FETCH, S_MEMRD, S_MEMWR}) && !bus.memReady;
  assign memTimeout = memWait && (MEM_WAIT_MAX != 0) && (waitCnt == WAIT_LAST);

  always_comb begin
    aluOp = ALUOP_ADD;
    case (state)
      S_EXER:   aluOp = ALUOP_RTYPE;
      S_EXEI:   aluOp = ALUOP_ITYPE;
      S_BRANCH: aluOp = ALUOP_SUB;
      default:  aluOp = ALUOP_ADD;
    endcase
  end

  riscv_mc_ctrl_fsm_aludec u_aludec (
    .aluOp    (aluOp),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .aluCtrl  (aluCtrl),
    .illegal  (aluIllegal)
  );

  always_comb begin
    stateNext = state;
    ctrl      = '0;
    case (state)
      S_FETCH: begin
        ctrl.resultSrc = RES_ALU;
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.irWrEn    = bus.memReady;
        ctrl.pcWrEn    = bus.memReady;
        if (bus.memReady) stateNext = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures the branch/JAL target while the opcode is decoded
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: stateNext = S_MEMADR;
          OP_RTYPE:          stateNext = S_EXER;
          OP_ITYPE:          stateNext = S_EXEI;
          OP_BRANCH:         stateNext = S_BRANCH;
          OP_JAL:            stateNext = S_JAL;
          OP_JALR:           stateNext = S_JALR1;
          OP_LUI:            stateNext = S_LUI;
          default:           stateNext = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        stateNext    = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
        if (bus.memReady) stateNext = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.resultSrc = RES_MEMDATA;
        ctrl.regWrEn   = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNext      = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.memWrEn   = 1'b1;
        ctrl.instrDone = bus.memReady;
        if (bus.memReady) stateNext = S_FETCH;
      end
      S_EXER, S_EXEI: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = (state == S_EXEI) ? SRCB_IMM : SRCB_RS2;
        stateNext    = aluIllegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regWrEn   = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNext      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.aluSrcA   = SRCA_RS1;
        ctrl.aluSrcB   = SRCB_RS2;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.instrDone = 1'b1;
        stateNext      = S_FETCH;
        case (bus.funct3)
          3'b000:  ctrl.pcWrEn = bus.zero;
          3'b001:  ctrl.pcWrEn = !bus.zero;
          3'b100:  ctrl.pcWrEn = bus.lt;
          3'b101:  ctrl.pcWrEn = !bus.lt;
          default: stateNext   = S_TRAP;
        endcase
      end
      S_JAL, S_JALR2: begin
        // PC takes the target in ALUOut while the ALU forms the link address
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.pcWrEn    = 1'b1;
        ctrl.aluSrcA   = SRCA_OLDPC;
        ctrl.aluSrcB   = SRCB_FOUR;
        stateNext      = S_ALUWB;
      end
      S_JALR1: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        stateNext    = S_JALR2;
      end
      S_LUI: begin
        ctrl.aluSrcA = SRCA_ZERO;
        ctrl.aluSrcB = SRCB_IMM;
        stateNext    = S_ALUWB;
      end
      S_TRAP:  stateNext = S_TRAP;
      default: stateNext = S_TRAP;
    endcase
    if (memTimeout) stateNext = S_TRAP;
  end

  // Count consecutive wait cycles within one memory state only
  always_comb begin
    waitCntNext = '0;
    if (memWait && stateNext == state) waitCntNext = waitCnt + CNT_W'(1);
  end

  // Reset cycle must never leave a write enable on
  assign ctrlOut = rst ? '0 : ctrl;

  assign bus.pcWrEn    = ctrlOut.pcWrEn;
  assign bus.adrSrc    = ctrlOut.adrSrc;
  assign bus.memWrEn   = ctrlOut.memWrEn;
  assign bus.irWrEn    = ctrlOut.irWrEn;
  assign bus.regWrEn   = ctrlOut.regWrEn;
  assign bus.resultSrc = ctrlOut.resultSrc;
  assign bus.aluSrcA   = ctrlOut.aluSrcA;
  assign bus.aluSrcB   = ctrlOut.aluSrcB;
  assign bus.instrDone = ctrlOut.instrDone;
  assign bus.aluCtrl   = rst ? ALU_ADD : aluCtrl;
  assign bus.immSrc    = rst ? IMM_I : immSrcOf(bus.opcode);
  assign bus.state     = state;
  assign bus.trap      = (state == S_TRAP);

endmodule
